alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with a valid/ready request and result interface.
//
// Single-cycle ops (add/sub/logic/shift/compare) return their result one
// clock after the request is accepted. The optional shift-add multiplier
// (op 0000) retires one multiplier bit per clock and returns WIDTH clocks
// after accept.
//
// Build option:
//   ALU_MC_MUL_EN  defined   -> op 0000 is an unsigned shift-add multiply.
//                  undefined -> op 0000 is an undefined op; multiplier and
//                               MUL state are not built; busy is tied 0.
//
// Parameters:
//   WIDTH      operand/result width (8, 16, 32 or 64)
//   SHW        shift-amount width, derived from WIDTH
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   in_valid, in_ready         request handshake
//   op, operand_a, operand_b   operation code and operands
//   shamt                      shift amount (shifts only)
//   out_valid, out_ready       result handshake
//   result                     WIDTH-bit result
//   zero, negative,
//   overflow, carry            status flags, registered with result
//   busy                       multiply in progress
//   fsm_state                  controller state (00 idle, 01 mul, 10 hold)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high in IDLE/HOLD when the output slot is empty or
// being drained this cycle; out_valid stays high with result/flags frozen
// until out_ready is seen. A retiring result and a new request may transfer
// on the same edge.
// ---------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             carry,
   output logic             busy,
   output logic [1:0]       fsm_state
);

   // ------------------------------------------------------------------
   // Operation codes
   // ------------------------------------------------------------------
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1010;
   localparam logic [3:0] OP_SUBU = 4'b1011;
   localparam logic [3:0] OP_ADDU = 4'b1100;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_SLT  = 4'b1110;
   localparam logic [3:0] OP_SLTU = 4'b1111;
`ifdef ALU_MC_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'b0000;
`endif

   // ------------------------------------------------------------------
   // Controller state
   // ------------------------------------------------------------------
`ifdef ALU_MC_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd2
   } state_t;
`endif

   state_t state;
   state_t state_next;

   logic accept;
   logic is_mul_req;
   logic mul_last;

`ifdef ALU_MC_MUL_EN
   assign is_mul_req = (op == OP_MUL);
`else
   assign is_mul_req = 1'b0;
`endif

   // A result is on the output exactly while the controller is in HOLD.
   assign out_valid = (state == S_HOLD);
   assign in_ready  = ((state == S_IDLE) || (state == S_HOLD)) &&
                      (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign fsm_state = state;

`ifdef ALU_MC_MUL_EN
   assign busy = (state == S_MUL);
`else
   assign busy = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Single-cycle datapath
   // ------------------------------------------------------------------
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt_s;
   logic             borrow;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_cy;

   assign add_full = {1'b0, operand_a} + {1'b0, operand_b};
   // MSB of a zero-extended subtraction is the unsigned borrow (a < b).
   assign sub_full = {1'b0, operand_a} - {1'b0, operand_b};
   assign borrow   = sub_full[WIDTH];

   // Signed overflow: like-signed operands (add) / unlike-signed operands
   // (sub) producing a result whose sign differs from operand_a.
   assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                    (add_full[WIDTH-1] != operand_a[WIDTH-1]);
   assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != operand_a[WIDTH-1]);
   assign slt_s   = ($signed(operand_a) < $signed(operand_b));

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_cy  = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_ovf = add_ovf;
            alu_cy  = add_full[WIDTH];
         end
         OP_ADDU: begin
            alu_res = add_full[WIDTH-1:0];
            alu_cy  = add_full[WIDTH];
         end
         OP_SUB: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_ovf = sub_ovf;
            alu_cy  = borrow;
         end
         OP_SUBU: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_cy  = borrow;
         end
         OP_AND:  alu_res = operand_a & operand_b;
         OP_OR:   alu_res = operand_a | operand_b;
         OP_XOR:  alu_res = operand_a ^ operand_b;
         OP_NOT:  alu_res = ~operand_a;
         OP_NOR:  alu_res = ~(operand_a | operand_b);
         OP_SLL:  alu_res = operand_a << shamt;
         OP_SRL:  alu_res = operand_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(operand_a) >>> shamt);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_s};
         OP_SLTU: begin
            alu_res = {{(WIDTH-1){1'b0}}, borrow};
            alu_cy  = borrow;
         end
         // Undefined codes (and 0000 without the multiplier) give a zero
         // result; zero flag follows from the result below.
         default: begin
            alu_res = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shift-add multiplier: {mul_hi, mul_lo} starts as {0, operand_b};
   // each step adds the multiplicand into the high half when the current
   // multiplier bit is set, then shifts the pair right by one.
   // ------------------------------------------------------------------
`ifdef ALU_MC_MUL_EN
   logic [WIDTH-1:0] mul_mcand;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [SHW-1:0]   mul_cnt;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   assign step_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_mcand} : '0);
   assign step_hi  = step_sum[WIDTH:1];
   assign step_lo  = {step_sum[0], mul_lo[WIDTH-1:1]};
   assign mul_last = (state == S_MUL) && (mul_cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_mcand <= '0;
         mul_hi    <= '0;
         mul_lo    <= '0;
         mul_cnt   <= '0;
      end else if (accept && is_mul_req) begin
         mul_mcand <= operand_a;
         mul_hi    <= '0;
         mul_lo    <= operand_b;
         mul_cnt   <= '0;
      end else if (state == S_MUL) begin
         mul_hi  <= step_hi;
         mul_lo  <= step_lo;
         mul_cnt <= mul_cnt + SHW'(1);
      end
   end
`else
   assign mul_last = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = is_mul_req ? state_t'(2'd1) : S_HOLD;
            end
         end
`ifdef ALU_MC_MUL_EN
         S_MUL: begin
            if (mul_last) begin
               state_next = S_HOLD;
            end
         end
`endif
         S_HOLD: begin
            // accept implies out_ready here, so the held result retires.
            if (accept) begin
               state_next = is_mul_req ? state_t'(2'd1) : S_HOLD;
            end else if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Result and flag registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         zero     <= 1'b0;
         negative <= 1'b0;
         overflow <= 1'b0;
         carry    <= 1'b0;
      end else if (accept && !is_mul_req) begin
         result   <= alu_res;
         zero     <= (alu_res == '0);
         negative <= alu_res[WIDTH-1];
         overflow <= alu_ovf;
         carry    <= alu_cy;
      end
`ifdef ALU_MC_MUL_EN
      else if (mul_last) begin
         // Low half is the result; any bit in the high half is overflow.
         result   <= step_lo;
         zero     <= (step_lo == '0);
         negative <= step_lo[WIDTH-1];
         overflow <= |step_hi;
         carry    <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc (WIDTH=32).
// Expected results are pushed to exp_q when a request is accepted and
// compared when the result handshake completes.
// ---------------------------------------------------------------------------
module tb_alu_mc;

   localparam int W   = 32;
   localparam int SHW = 5;
   localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (W - 1));

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     op;
   logic [W-1:0]   operand_a;
   logic [W-1:0]   operand_b;
   logic [SHW-1:0] shamt;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   result;
   logic           zero;
   logic           negative;
   logic           overflow;
   logic           carry;
   logic           busy;
   logic [1:0]     fsm_state;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow),
      .carry     (carry),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W+3:0] exp_q[$];
   logic [W+3:0] mon_e;
   int errors = 0;
   int checks = 0;
   int pops = 0;
   logic rand_ready = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: returns {result, zero, negative, overflow, carry}.
   function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [SHW-1:0] s);
      logic [W-1:0] r;
      logic         ov;
      logic         cy;
      longint       sa;
      longint       sb;
      longint       t;
      logic [63:0]  wide;
      r  = '0;
      ov = 1'b0;
      cy = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         4'h2: begin
            t = sa + sb; r = W'(t); ov = (t > SMAX) || (t < SMIN);
            wide = 64'(a) + 64'(b); cy = wide[W];
         end
         4'h3: begin
            t = sa - sb; r = W'(t); ov = (t > SMAX) || (t < SMIN); cy = (a < b);
         end
         4'h4: r = a & b;
         4'h5: r = a | b;
         4'h6: r = a ^ b;
         4'h7: r = ~a;
         4'h8: r = a << s;
         4'h9: r = a >> s;
         4'hA: r = ~(a | b);
         4'hB: begin r = a - b; cy = (a < b); end
         4'hC: begin wide = 64'(a) + 64'(b); r = wide[W-1:0]; cy = wide[W]; end
         4'hD: r = W'(sa >>> s);
         4'hE: r = {{(W-1){1'b0}}, (sa < sb)};
         4'hF: begin r = {{(W-1){1'b0}}, (a < b)}; cy = (a < b); end
`ifdef ALU_MC_MUL_EN
         4'h0: begin wide = 64'(a) * 64'(b); r = wide[W-1:0]; ov = (wide[63:W] != '0); end
`endif
         default: r = '0;
      endcase
      return {r, (r == '0), r[W-1], ov, cy};
   endfunction

   // ---------------- driver ----------------
   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [SHW-1:0] s);
      int waits;
      waits     = 0;
      in_valid  = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      shamt     = s;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'(waits), 64'd0);
         in_valid = 1'b0;
         @(posedge clk); #1;
      end else begin
         exp_q.push_back(model(o, a, b, s));
         @(posedge clk); #1;
         in_valid  = 1'b0;
         // Scramble inputs so an in-flight op cannot depend on them.
         op        = 4'($urandom_range(0, 15));
         operand_a = $urandom;
         operand_b = $urandom;
         shamt     = SHW'($urandom_range(0, W - 1));
      end
   endtask

   task automatic direct(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [SHW-1:0] s,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
      send(o, a, b, s);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_res"}, 64'(result), 64'(exp_res));
      check({tag, "_flags"}, 64'({zero, negative, overflow, carry}), 64'(exp_flags));
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_result", 64'(result), 64'(mon_e[W+3:4]));
            check("sb_flags", 64'({zero, negative, overflow, carry}), 64'(mon_e[3:0]));
            pops++;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [W+3:0] e4;
      int c0;
      int p0;
      int bad;
      int rises;
      int guard;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      reset     = 1'b1;
      in_valid  = 1'b1;
      op        = 4'h2;
      operand_a = 32'd5;
      operand_b = 32'd6;
      shamt     = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags", 64'({zero, negative, overflow, carry}), 64'd0);
      check("rst_state", 64'(fsm_state), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk); #1;
      check("rst_ignored_valid", 64'(out_valid), 64'd0);

      // Directed corner cases, back to back with out_ready=1.
      direct("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, '0, 32'h8000_0000, 4'b0110);
      direct("subu_brw", 4'hB, 32'h0, 32'h1, '0, 32'hFFFF_FFFF, 4'b0101);
      direct("sub_ovf", 4'h3, 32'h8000_0000, 32'h1, '0, 32'h7FFF_FFFF, 4'b0010);
      direct("slt", 4'hE, 32'hFFFF_FFFF, 32'h1, '0, 32'h1, 4'b0000);
      direct("sltu", 4'hF, 32'hFFFF_FFFF, 32'h1, '0, 32'h0, 4'b1000);
      direct("sra", 4'hD, 32'h8000_0000, 32'h0, 5'd31, 32'hFFFF_FFFF, 4'b0100);
      direct("srl", 4'h9, 32'h8000_0000, 32'h0, 5'd31, 32'h1, 4'b0000);
      direct("sll0", 4'h8, 32'h1, 32'h0, 5'd0, 32'h1, 4'b0000);
      direct("addu_cy", 4'hC, 32'hFFFF_FFFF, 32'h2, '0, 32'h1, 4'b0001);
      direct("nor", 4'hA, 32'hF0F0_0000, 32'h0F0F_0000, '0, 32'h0000_FFFF, 4'b0000);
      direct("undef1", 4'h1, 32'h1234, 32'h5678, '0, 32'h0, 4'b1000);
`ifndef ALU_MC_MUL_EN
      direct("undef0", 4'h0, 32'h1234, 32'h5678, '0, 32'h0, 4'b1000);
`endif

      // Throughput then stall.
      repeat (2) @(posedge clk);
      #1;
      c0 = cyc;
      p0 = pops;
      send(4'h2, 32'd10, 32'd20, '0);
      send(4'h2, 32'd30, 32'd40, '0);
      send(4'h2, 32'd50, 32'd60, '0);
      send(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
      out_ready = 1'b0;
      check("tput_cycles", 64'(cyc - c0), 64'd4);
      check("tput_pops", 64'(pops - p0), 64'd3);
      e4 = model(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_res", 64'(result), 64'(e4[W+3:4]));
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset while a result is held.
      out_ready = 1'b0;
      send(4'h6, 32'hAAAA_5555, 32'h0F0F_F0F0, '0);
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("hold_rst_valid", 64'(out_valid), 64'd0);
      check("hold_rst_result", 64'(result), 64'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

`ifdef ALU_MC_MUL_EN
      // Multiply: busy for WIDTH cycles, then result.
      send(4'h0, 32'h0001_0000, 32'h0001_0000, '0);
      bad = 0;
      for (int k = 0; k < W; k++) begin
         if (!(busy === 1'b1 && out_valid === 1'b0)) bad++;
         @(posedge clk); #1;
      end
      check("mul_busy_window", 64'(bad), 64'd0);
      check("mul_valid", 64'(out_valid), 64'd1);
      check("mul_busy_end", 64'(busy), 64'd0);
      check("mul_res", 64'(result), 64'd0);
      check("mul_flags", 64'({zero, negative, overflow, carry}), 64'b1010);
      @(posedge clk); #1;

      // Reset ten cycles into a multiply discards it.
      send(4'h0, 32'd1234, 32'd5678, '0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mulrst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      rises = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) rises++;
      end
      check("mulrst_no_valid", 64'(rises), 64'd0);
      check("mulrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
`endif

      // Random traffic with random back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: ra = 32'h8000_0000;
            1: ra = 32'h7FFF_FFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
         send(4'($urandom_range(0, 15)), ra, rb, SHW'($urandom_range(0, W - 1)));
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
